// File: rtl/ov7670_emulator_pkg.sv
// Shared camera package: default video timing, FSM state encoding, chroma
// constant and the test-pattern luma helper used by the OV7670 emulator.
package ov7670_emulator_pkg;

  localparam int unsigned DEF_H_PIX       = 320;
  localparam int unsigned DEF_V_PIX       = 240;
  localparam int unsigned DEF_H_BLANK     = 144;
  localparam int unsigned DEF_VSYNC_LINES = 3;
  localparam int unsigned DEF_V_BACK      = 17;
  localparam int unsigned DEF_V_FRONT     = 10;

  localparam int unsigned ADDR_W = 19;
  localparam logic [7:0]  CHROMA = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_t;

  // Test-pattern luma: diagonal ramp, wraps modulo 256.
  function automatic logic [7:0] pattern_y(input logic [7:0] x, input logic [7:0] y);
    return x + y;
  endfunction

endpackage

// File: rtl/ov7670_emulator_if.sv
// Camera-side bus of the emulator: emulated sensor outputs (pclk, vsync,
// href, data) plus the pixel-memory read port (pix_addr, pix_rd, pix_data).
//   master : the emulator (drives sensor signals and read requests)
//   slave  : the consumer / pixel memory (supplies pix_data)
interface ov7670_emulator_if;
  import ov7670_emulator_pkg::*;

  logic              pclk;
  logic              vsync;
  logic              href;
  logic [7:0]        data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rd;
  logic [7:0]        pix_data;

  modport master (
    output pclk, vsync, href, data, pix_addr, pix_rd,
    input  pix_data
  );

  modport slave (
    input  pclk, vsync, href, data, pix_addr, pix_rd,
    output pix_data
  );

endinterface

// File: rtl/ov7670_timing_gen.sv
// Frame/line timing for the emulator: state machine, byte and line counters,
// href and vsync. Everything advances only on tick (the pclk falling update).
// Ports: clk_50, reset (sync, active-high), tick, enable in; registered state,
// href, vsync out; nxt_* expose the values that load on the coming tick so the
// data path can register its byte in the same update cycle.
module ov7670_timing_gen
  import ov7670_emulator_pkg::*;
#(
  parameter  int unsigned H_PIX       = DEF_H_PIX,
  parameter  int unsigned V_PIX       = DEF_V_PIX,
  parameter  int unsigned H_BLANK     = DEF_H_BLANK,
  parameter  int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter  int unsigned V_BACK      = DEF_V_BACK,
  parameter  int unsigned V_FRONT     = DEF_V_FRONT,
  localparam int unsigned LINE_LEN    = 2 * H_PIX + H_BLANK,
  localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_PIX + V_FRONT,
  localparam int unsigned BW          = $clog2(LINE_LEN),
  localparam int unsigned LW          = $clog2(FRAME_LINES)
) (
  input  logic          clk_50,
  input  logic          reset,
  input  logic          tick,
  input  logic          enable,
  output cam_state_t    state,
  output logic          href,
  output logic          vsync,
  output cam_state_t    nxt_state,
  output logic [BW-1:0] nxt_byte,
  output logic [LW-1:0] nxt_line,
  output logic          nxt_href
);

  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic [LW-1:0] last_line;

  always_comb begin
    last_line = '0;
    nxt_state = state;
    nxt_byte  = '0;
    nxt_line  = '0;
    case (state)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBACK:  last_line = LW'(V_BACK - 1);
      ST_ACTIVE: last_line = LW'(V_PIX - 1);
      ST_VFRONT: last_line = LW'(V_FRONT - 1);
      default:   last_line = '0;
    endcase
    if (state == ST_IDLE) begin
      if (enable) nxt_state = ST_VSYNC;
    end else if (byte_cnt != BW'(LINE_LEN - 1)) begin
      nxt_byte = byte_cnt + BW'(1);
      nxt_line = line_cnt;
    end else if (line_cnt != last_line) begin
      nxt_line = line_cnt + LW'(1);
    end else begin
      case (state)
        ST_VSYNC:  nxt_state = ST_VBACK;
        ST_VBACK:  nxt_state = ST_ACTIVE;
        ST_ACTIVE: nxt_state = ST_VFRONT;
        ST_VFRONT: nxt_state = enable ? ST_VSYNC : ST_IDLE;
        default:   nxt_state = ST_IDLE;
      endcase
    end
    nxt_href = (nxt_state == ST_ACTIVE) && (nxt_byte < BW'(2 * H_PIX));
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
      href     <= 1'b0;
      vsync    <= 1'b0;
    end else if (tick) begin
      state    <= nxt_state;
      byte_cnt <= nxt_byte;
      line_cnt <= nxt_line;
      href     <= nxt_href;
      vsync    <= (nxt_state == ST_VSYNC);
    end
  end

endmodule

// File: rtl/ov7670_emulator.sv
// OV7670 camera emulator: produces pclk (clk_50/2), vsync, href and a
// YCbCr 4:2:2 byte stream (Cb Y0 Cr Y1) from either an internal diagonal test
// pattern or an external pixel memory.
// Ports: clk_50, reset (sync, active-high), enable (frame start permit),
// pattern_en (1 = test pattern, latched per frame), cam (master side of the
// sensor/memory bus), frame_start (1-cycle pulse on VSYNC entry), busy.
module ov7670_emulator
  import ov7670_emulator_pkg::*;
#(
  parameter  int unsigned H_PIX       = DEF_H_PIX,
  parameter  int unsigned V_PIX       = DEF_V_PIX,
  parameter  int unsigned H_BLANK     = DEF_H_BLANK,
  parameter  int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter  int unsigned V_BACK      = DEF_V_BACK,
  parameter  int unsigned V_FRONT     = DEF_V_FRONT,
  localparam int unsigned LINE_LEN    = 2 * H_PIX + H_BLANK,
  localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_PIX + V_FRONT,
  localparam int unsigned BW          = $clog2(LINE_LEN),
  localparam int unsigned LW          = $clog2(FRAME_LINES)
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                pattern_en,
  ov7670_emulator_if.master   cam,
  output logic                frame_start,
  output logic                busy
);

  logic              pclk_q;
  logic              tick;
  cam_state_t        state;
  cam_state_t        nxt_state;
  logic              href;
  logic              vsync;
  logic              nxt_href;
  logic [BW-1:0]     nxt_byte;
  logic [LW-1:0]     nxt_line;
  logic              pattern_q;
  logic [7:0]        data_q;
  logic              pix_rd_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [ADDR_W-1:0] addr_cnt;

  // Update cycle: pclk is high now and is driven low at this edge, so all
  // sensor outputs change there and are stable at the next pclk rise.
  assign tick = pclk_q;

  ov7670_timing_gen #(
    .H_PIX       (H_PIX),
    .V_PIX       (V_PIX),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .clk_50    (clk_50),
    .reset     (reset),
    .tick      (tick),
    .enable    (enable),
    .state     (state),
    .href      (href),
    .vsync     (vsync),
    .nxt_state (nxt_state),
    .nxt_byte  (nxt_byte),
    .nxt_line  (nxt_line),
    .nxt_href  (nxt_href)
  );

  always_ff @(posedge clk_50) begin
    if (reset) pclk_q <= 1'b0;
    else       pclk_q <= ~pclk_q;
  end

  // Memory fetch: the read strobe is issued with the chroma byte, so it is
  // high in the pclk-rise cycle; the memory answers in the following update
  // cycle, where the value is registered straight onto the bus as the Y byte.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      data_q      <= '0;
      pix_rd_q    <= 1'b0;
      pix_addr_q  <= '0;
      addr_cnt    <= '0;
      frame_start <= 1'b0;
      pattern_q   <= 1'b0;
    end else begin
      pix_rd_q    <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        if (nxt_state == ST_VSYNC && state != ST_VSYNC) begin
          frame_start <= 1'b1;
          pattern_q   <= pattern_en;
          addr_cnt    <= '0;
        end
        if (!nxt_href) begin
          data_q <= '0;
        end else if (!nxt_byte[0]) begin
          data_q <= CHROMA;
          if (!pattern_q) begin
            pix_rd_q   <= 1'b1;
            pix_addr_q <= addr_cnt;
            addr_cnt   <= addr_cnt + ADDR_W'(1);
          end
        end else if (pattern_q) begin
          data_q <= pattern_y(8'(nxt_byte >> 1), 8'(nxt_line));
        end else begin
          data_q <= cam.pix_data;
        end
      end
    end
  end

  assign cam.pclk     = pclk_q;
  assign cam.vsync    = vsync;
  assign cam.href     = href;
  assign cam.data     = data_q;
  assign cam.pix_rd   = pix_rd_q;
  assign cam.pix_addr = pix_addr_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_ov7670_emulator.sv
// Scoreboard bench for ov7670_emulator with reduced timing so whole frames fit.
module tb_ov7670_emulator;

  localparam int H_PIX       = 16;
  localparam int V_PIX       = 8;
  localparam int H_BLANK     = 6;
  localparam int VSYNC_LINES = 2;
  localparam int V_BACK      = 3;
  localparam int V_FRONT     = 2;
  localparam int LINE        = 2 * H_PIX + H_BLANK;  // 38 pclk
  localparam int FRAME_CLKS  = 2 * LINE * (VSYNC_LINES + V_BACK + V_PIX + V_FRONT); // 1140

  logic clk_50 = 1'b0;
  logic reset;
  logic enable;
  logic pattern_en;
  logic frame_start;
  logic busy;

  ov7670_emulator_if cam();

  ov7670_emulator #(
    .H_PIX       (H_PIX),
    .V_PIX       (V_PIX),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .enable      (enable),
    .pattern_en  (pattern_en),
    .cam         (cam),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk_50 = ~clk_50;

  // Pixel memory: returns addr[7:0] one cycle after a read, junk otherwise.
  always @(posedge clk_50) cam.pix_data <= cam.pix_rd ? cam.pix_addr[7:0] : 8'hEE;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit pat);
    for (int y = 0; y < V_PIX; y++)
      for (int x = 0; x < H_PIX; x++) begin
        exp_q.push_back(8'h80);
        if (pat) exp_q.push_back(8'((x + y) % 256));
        else     exp_q.push_back(8'((y * H_PIX + x) % 256));
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pclk"},  32'(cam.pclk), 0);
    chk({tag, "_vsync"}, 32'(cam.vsync), 0);
    chk({tag, "_href"},  32'(cam.href), 0);
    chk({tag, "_data"},  32'(cam.data), 0);
    chk({tag, "_rd"},    32'(cam.pix_rd), 0);
    chk({tag, "_addr"},  32'(cam.pix_addr), 0);
    chk({tag, "_fs"},    32'(frame_start), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic wait_fs(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_50);
      if (frame_start) found = 1'b1;
    end
    chk("frame_start_seen", 32'(found), 1);
  endtask

  // Monitor state
  int   hrun = 0, lrun = 0, vrun = 0, line_idx = 0, f = 0, n_fs = 0, exp_addr = 0;
  int   rd_cnt[8] = '{default: 0};
  logic prev_href = 1'b0, prev_vsync = 1'b0, prev_fs = 1'b0;
  logic [7:0] cap_p5b1 = 8'hFF, cap_p5b3 = 8'hFF, cap_m = 8'hFF;

  always @(negedge clk_50) begin
    if (reset) begin
      prev_href = 1'b0; prev_vsync = 1'b0; prev_fs = 1'b0;
      hrun = 0; lrun = 0; vrun = 0; line_idx = 0; exp_addr = 0;
    end else begin
      if (frame_start) begin
        chk("fs_single", 32'(prev_fs), 0);
        n_fs++;
        if (f < 7) f++;
        line_idx = 0;
        exp_addr = 0;
      end
      prev_fs = frame_start;
      if (cam.pix_rd) begin
        chk("rd_phase", 32'(cam.pclk), 0);
        chk("pix_addr", 32'(cam.pix_addr), 32'(exp_addr));
        exp_addr++;
        rd_cnt[f]++;
      end
      if (cam.pclk) begin
        if (cam.href) begin
          if (!prev_href && line_idx > 0) chk("h_blank", 32'(lrun), H_BLANK);
          if (f == 1 && line_idx == 5 && hrun == 1) cap_p5b1 = cam.data;
          if (f == 1 && line_idx == 5 && hrun == 3) cap_p5b3 = cam.data;
          if (f == 2 && line_idx == 2 && hrun == 21) cap_m = cam.data;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte_unexpected actual=0x%0h required=none t=%0t", cam.data, $time);
          end else begin
            chk("byte", 32'(cam.data), 32'(exp_q.pop_front()));
          end
          hrun++;
        end else begin
          if (prev_href) begin
            chk("href_len", 32'(hrun), 2 * H_PIX);
            line_idx++;
            hrun = 0;
            lrun = 0;
          end
          chk("blank_data", 32'(cam.data), 0);
          lrun++;
        end
        if (cam.vsync) vrun++;
        else if (prev_vsync) begin
          chk("vsync_len", 32'(vrun), VSYNC_LINES * LINE);
          vrun = 0;
        end
        prev_href  = cam.href;
        prev_vsync = cam.vsync;
      end
    end
  end

  initial begin
    int  n;
    bit  done;
    reset = 1'b1; enable = 1'b1; pattern_en = 1'b1;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    check_reset_outputs("rst0");
    push_frame(1'b1);
    @(posedge clk_50); #1 reset = 1'b0;

    // Frame 1: pattern; pattern_en drops mid-frame and applies to frame 2 only.
    wait_fs(20);
    repeat (700) @(negedge clk_50);
    @(posedge clk_50); #1 pattern_en = 1'b0;
    push_frame(1'b0);

    // Frame 2: memory; enable drops in active line 4, frame must still finish.
    wait_fs(1200);
    n = 1; done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (i == 700) begin
        @(posedge clk_50); #1 enable = 1'b0; pattern_en = 1'b1;
      end
      @(negedge clk_50);
      if (busy) n++;
      else done = 1'b1;
    end
    chk("frame_len", 32'(n), FRAME_CLKS);
    chk("fs_count_f2", 32'(n_fs), 2);
    repeat (300) @(negedge clk_50);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_vsync", 32'(cam.vsync), 0);
    chk("idle_fs_count", 32'(n_fs), 2);

    // Frame 3: memory, aborted by reset in active line 2.
    @(posedge clk_50); #1 pattern_en = 1'b0; enable = 1'b1;
    push_frame(1'b0);
    wait_fs(20);
    repeat (560) @(negedge clk_50);
    @(posedge clk_50); #1 reset = 1'b1;
    @(posedge clk_50);
    @(negedge clk_50);
    check_reset_outputs("rst_mid");
    exp_q.delete();
    push_frame(1'b0);
    @(posedge clk_50); #1 reset = 1'b0;

    // Frame 4: full memory frame from address 0, then stop.
    wait_fs(20);
    repeat (700) @(negedge clk_50);
    @(posedge clk_50); #1 enable = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_50);
      if (!busy) done = 1'b1;
    end
    chk("end_idle", 32'(done), 1);

    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("fs_total", 32'(n_fs), 4);
    chk("rd_pattern_frame", 32'(rd_cnt[1]), 0);
    chk("rd_frame2", 32'(rd_cnt[2]), 128);
    chk("rd_frame4", 32'(rd_cnt[4]), 128);
    chk("pat_l5_b1", 32'(cap_p5b1), 32'h05);
    chk("pat_l5_b3", 32'(cap_p5b3), 32'h06);
    chk("mem_x10_y2", 32'(cap_m), 32'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
